// File: rtl/seg7_apb_scan.sv
// seg7_apb_scan: APB-mapped multiplexed 7-segment display controller.
// It provides a configurable digit count, a programmable scan period, per-digit
// blanking and decimal points, PWM brightness and a readable status register.
// All display outputs are registered and active-low.
module seg7_apb_scan #(
    parameter int              DIGITS      = 8,
    parameter int              DIV_W       = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd49999
) (
    input  logic              pclk_i,
    input  logic              presetn_i,
    input  logic [31:0]       paddr_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [31:0]       pwdata_i,
    input  logic [3:0]        pstrb_i,
    output logic              pready_o,
    output logic [31:0]       prdata_o,
    output logic              pslverr_o,
    output logic [6:0]        seg_o,
    output logic              dp_o,
    output logic [DIGITS-1:0] an_o
);

    // Storable bits of DATA and of the per-digit masks for this digit count
    localparam logic [31:0] DATA_MASK  = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << (4 * DIGITS)) - 32'd1);
    localparam logic [7:0]  DIGIT_MASK = (DIGITS >= 8) ? 8'hFF
                                                       : 8'((16'd1 << DIGITS) - 16'd1);
    localparam logic [2:0]  LAST_IDX   = 3'(DIGITS - 1);

    logic [31:0]      data_q;
    logic             en_q;
    logic [7:0]       dp_mask_q;
    logic [7:0]       blank_q;
    logic [DIV_W-1:0] div_q;
    logic [4:0]       bright_q;

    logic [2:0]       idx_q;
    logic [DIV_W-1:0] slot_q;
    logic [3:0]       pwm_q;

    logic [7:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    logic             access;
    logic             addr_ok;
    logic             err;
    logic             wr_commit;
    logic [2:0]       word_addr;
    logic [31:0]      rd_view;
    logic [31:0]      merged;
    logic             digit_on;
    logic [3:0]       nibble;
    logic [6:0]       seg_dec;

    // Combine byte strobes: strobed bytes take write data, others keep the old value
    function automatic logic [31:0] strobe_merge(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    assign word_addr = paddr_i[4:2];
    assign access    = psel_i & penable_i;
    assign addr_ok   = (paddr_i[1:0] == 2'b00) && (paddr_i <= 32'h0000_0010);
    assign err       = access & (~addr_ok | (pwrite_i & (word_addr == 3'd4)));
    assign wr_commit = access & pwrite_i & ~err;

    // Register view as seen by a read; also the base for strobed writes
    always_comb begin
        rd_view = 32'h0;
        case (word_addr)
            3'd0: rd_view = data_q;
            3'd1: rd_view = {8'h00, blank_q, dp_mask_q, 7'h00, en_q};
            3'd2: rd_view = 32'(div_q);
            3'd3: rd_view = {27'h0, bright_q};
            3'd4: rd_view = {23'h0, en_q, 5'h00, idx_q};
            default: rd_view = 32'h0;
        endcase
    end

    assign merged    = strobe_merge(rd_view, pwdata_i, pstrb_i);
    assign pready_o  = psel_i;
    assign prdata_o  = (presetn_i & access & ~pwrite_i & ~err) ? rd_view : 32'h0;
    assign pslverr_o = presetn_i & err;

    // Configuration registers, updated on a committed error-free write
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            data_q    <= 32'h0;
            en_q      <= 1'b1;
            dp_mask_q <= 8'h00;
            blank_q   <= 8'h00;
            div_q     <= DEFAULT_DIV;
            bright_q  <= 5'd16;
        end else if (wr_commit) begin
            case (word_addr)
                3'd0: data_q <= merged & DATA_MASK;
                3'd1: begin
                    en_q      <= merged[0];
                    dp_mask_q <= merged[15:8] & DIGIT_MASK;
                    blank_q   <= merged[23:16] & DIGIT_MASK;
                end
                3'd2: div_q <= (merged[DIV_W-1:0] == '0) ? DIV_W'(1) : merged[DIV_W-1:0];
                3'd3: bright_q <= (merged > 32'd16) ? 5'd16 : merged[4:0];
                default: ;
            endcase
        end
    end

    // Scan and PWM counters; disabling parks everything at zero so re-enable starts at digit 0
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            idx_q  <= 3'd0;
            slot_q <= '0;
            pwm_q  <= 4'd0;
        end else if (!en_q) begin
            idx_q  <= 3'd0;
            slot_q <= '0;
            pwm_q  <= 4'd0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
            if (slot_q >= div_q) begin
                slot_q <= '0;
                idx_q  <= (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
            end else begin
                slot_q <= slot_q + DIV_W'(1);
            end
        end
    end

    assign digit_on = en_q & ~blank_q[idx_q] & ({1'b0, pwm_q} < bright_q);
    assign nibble   = data_q[{idx_q, 2'b00} +: 4];

    // Hex to active-high segment pattern, bit0 = segment a
    always_comb begin
        seg_dec = 7'h00;
        case (nibble)
            4'h0: seg_dec = 7'h3F;
            4'h1: seg_dec = 7'h06;
            4'h2: seg_dec = 7'h5B;
            4'h3: seg_dec = 7'h4F;
            4'h4: seg_dec = 7'h66;
            4'h5: seg_dec = 7'h6D;
            4'h6: seg_dec = 7'h7D;
            4'h7: seg_dec = 7'h07;
            4'h8: seg_dec = 7'h7F;
            4'h9: seg_dec = 7'h6F;
            4'hA: seg_dec = 7'h77;
            4'hB: seg_dec = 7'h7C;
            4'hC: seg_dec = 7'h39;
            4'hD: seg_dec = 7'h5E;
            4'hE: seg_dec = 7'h79;
            4'hF: seg_dec = 7'h71;
            default: seg_dec = 7'h00;
        endcase
    end

    // Registered active-low pin drivers, one clock behind the scan state
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            an_q  <= 8'hFF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= digit_on ? ~(8'd1 << idx_q) : 8'hFF;
            seg_q <= digit_on ? ~seg_dec : 7'h7F;
            dp_q  <= ~(dp_mask_q[idx_q] & digit_on);
        end
    end

    assign an_o  = an_q[DIGITS-1:0];
    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: tb/tb_seg7_apb_scan.sv
// Directed testbench for seg7_apb_scan with hand-computed expectations.
module tb_seg7_apb_scan;

    logic        clk;
    logic        rst_n;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;

    int errors = 0;
    int checks = 0;

    seg7_apb_scan #(.DIGITS(8), .DIV_W(16), .DEFAULT_DIV(16'd49999)) dut (
        .pclk_i    (clk),
        .presetn_i (rst_n),
        .paddr_i   (paddr),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .pwdata_i  (pwdata),
        .pstrb_i   (pstrb),
        .pready_o  (pready),
        .prdata_o  (prdata),
        .pslverr_o (pslverr),
        .seg_o     (seg),
        .dp_o      (dp),
        .an_o      (an)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Active-high segment pattern for a hex digit, bit0 = a
    function automatic logic [6:0] segOf(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Count a comparison and report any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete APB transfer; starts and returns just after a rising edge
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, output logic [31:0] rdata,
                                 output logic err, output logic rdy);
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        pstrb   = strb;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk);
        #1 penable = 1'b1;
        #1;
        rdata = prdata;
        err   = pslverr;
        rdy   = pready;
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
    endtask

    // Full-word write expected to complete without error
    task automatic regWrite(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        logic        e, r;
        applyStimulus(1'b1, addr, wdata, 4'hF, rd, e, r);
        checkOutput("wr_slverr", {31'h0, e}, 32'h0);
    endtask

    // Read expected to complete without error, checked against an expected value
    task automatic regRead(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        e, r;
        applyStimulus(1'b0, addr, 32'h0, 4'h0, rd, e, r);
        checkOutput(tag, rd, exp);
        checkOutput("rd_slverr", {31'h0, e}, 32'h0);
        checkOutput("rd_pready", {31'h0, r}, 32'h1);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e, r;
        logic [7:0]  exp_an;
        logic [6:0]  exp_seg;
        int          d;

        rst_n   = 1'b0;
        paddr   = 32'h0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        pwdata  = 32'h0;
        pstrb   = 4'h0;

        // Outputs held in reset
        #22;
        checkOutput("rst_an", {24'h0, an}, 32'h0000_00FF);
        checkOutput("rst_seg", {25'h0, seg}, 32'h0000_007F);
        checkOutput("rst_dp", {31'h0, dp}, 32'h1);
        checkOutput("rst_prdata", prdata, 32'h0);
        checkOutput("rst_slverr", {31'h0, pslverr}, 32'h0);
        rst_n = 1'b1;
        nextCycle();

        // Reset register values
        regRead("rst_data", 32'h00, 32'h0000_0000);
        regRead("rst_ctrl", 32'h04, 32'h0000_0001);
        regRead("rst_div", 32'h08, 32'd49999);
        regRead("rst_bright", 32'h0C, 32'd16);
        regRead("rst_status", 32'h10, 32'h0000_0100);

        // Basic scan: DIV=3, each anode low for 4 clocks, digits show their index
        regWrite(32'h04, 32'h0);
        regWrite(32'h08, 32'd3);
        regWrite(32'h00, 32'h7654_3210);
        regWrite(32'h04, 32'h1);
        checkOutput("scan_first_off", {24'h0, an}, 32'h0000_00FF);
        for (int k = 1; k <= 36; k++) begin
            nextCycle();
            d       = ((k - 1) / 4) % 8;
            exp_an  = ~(8'd1 << d);
            exp_seg = ~segOf(d);
            checkOutput("scan_an", {24'h0, an}, {24'h0, exp_an});
            checkOutput("scan_seg", {25'h0, seg}, {25'h0, exp_seg});
        end

        // Byte strobes
        regWrite(32'h00, 32'h0);
        applyStimulus(1'b1, 32'h00, 32'hFFFF_FFFF, 4'b0010, rd, e, r);
        regRead("strobe_data", 32'h00, 32'h0000_FF00);
        regWrite(32'h00, 32'h7654_3210);

        // Blank digit 2, decimal point on digit 1
        regWrite(32'h04, 32'h0);
        regWrite(32'h04, 32'h0004_0201);
        for (int k = 1; k <= 32; k++) begin
            nextCycle();
            d      = ((k - 1) / 4) % 8;
            exp_an = (d == 2) ? 8'hFF : ~(8'd1 << d);
            checkOutput("blank_an", {24'h0, an}, {24'h0, exp_an});
            checkOutput("blank_dp", {31'h0, dp}, (d == 1) ? 32'h0 : 32'h1);
        end
        regRead("ctrl_rb", 32'h04, 32'h0004_0201);

        // Error responses
        applyStimulus(1'b0, 32'h14, 32'h0, 4'h0, rd, e, r);
        checkOutput("err_rd14_slverr", {31'h0, e}, 32'h1);
        checkOutput("err_rd14_data", rd, 32'h0);
        applyStimulus(1'b1, 32'h02, 32'hDEAD_BEEF, 4'hF, rd, e, r);
        checkOutput("err_wr02_slverr", {31'h0, e}, 32'h1);
        regRead("err_wr02_data", 32'h00, 32'h7654_3210);
        applyStimulus(1'b1, 32'h10, 32'h0000_0005, 4'hF, rd, e, r);
        checkOutput("err_wrstat_slverr", {31'h0, e}, 32'h1);
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, e, r);
        checkOutput("err_rd100_slverr", {31'h0, e}, 32'h1);

        // PWM brightness: BRIGHT=4 lights 4 of every 16 clocks
        regWrite(32'h04, 32'h0);
        regWrite(32'h08, 32'd31);
        regWrite(32'h0C, 32'd4);
        regWrite(32'h04, 32'h1);
        for (int k = 1; k <= 40; k++) begin
            nextCycle();
            d      = ((k - 1) / 32) % 8;
            exp_an = (((k - 1) % 16) < 4) ? ~(8'd1 << d) : 8'hFF;
            checkOutput("pwm_an", {24'h0, an}, {24'h0, exp_an});
        end
        regWrite(32'h0C, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            nextCycle();
            checkOutput("bright0_an", {24'h0, an}, 32'h0000_00FF);
        end
        regWrite(32'h0C, 32'd31);
        regRead("bright_sat", 32'h0C, 32'd16);

        // Disable mid-scan at digit 5, then re-enable
        regWrite(32'h04, 32'h0);
        regWrite(32'h08, 32'd3);
        regWrite(32'h04, 32'h1);
        repeat (20) @(posedge clk);
        #1;
        regWrite(32'h04, 32'h0);
        checkOutput("en_off_last", {24'h0, an}, 32'h0000_00DF);
        checkOutput("en_off_seg5", {25'h0, seg}, {25'h0, ~7'h6D});
        nextCycle();
        checkOutput("en_off_an", {24'h0, an}, 32'h0000_00FF);
        checkOutput("en_off_seg", {25'h0, seg}, 32'h0000_007F);
        regRead("en_off_status", 32'h10, 32'h0);
        regWrite(32'h04, 32'h1);
        checkOutput("reen_pre", {24'h0, an}, 32'h0000_00FF);
        nextCycle();
        checkOutput("reen_digit0", {24'h0, an}, 32'h0000_00FE);

        // DIV=0 is stored as 1: two-clock slots
        regWrite(32'h04, 32'h0);
        regWrite(32'h08, 32'd0);
        regRead("div0_rb", 32'h08, 32'd1);
        regWrite(32'h04, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            nextCycle();
            d      = ((k - 1) / 2) % 8;
            exp_an = ~(8'd1 << d);
            checkOutput("div1_an", {24'h0, an}, {24'h0, exp_an});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_apb_scan.md
Name: seg7_apb_scan

Overview:
- Parametrised APB-mapped multiplexed 7-segment display controller; next generation of the team's single-configuration display driver.
- Adds a configurable digit count, a programmable scan rate, per-digit blanking and decimal points, PWM brightness and a readable status register.
- Zero-wait-state APB slave with full error reporting.
- Sits on the peripheral APB bus and drives board cathode/anode pins directly.

Parameters:
- DIGITS, 8, number of multiplexed digits (1..8).
- DIV_W, 16, width of the scan-period divider.
- DEFAULT_DIV, 16'd49999, reset value of DIV (per-digit slot length = DIV+1 clocks).

Ports:
- pclk_i  in  1  clock
- presetn_i  in  1  asynchronous active-low reset
- paddr_i  in  32  byte address
- psel_i  in  1  APB select
- penable_i  in  1  APB access phase
- pwrite_i  in  1  1=write
- pwdata_i  in  32  write data
- pstrb_i  in  4  byte strobes
- pready_o  out  1  transfer ready
- prdata_o  out  32  read data
- pslverr_o  out  1  transfer error
- seg_o  out  7  cathodes a..g (bit0=a), active-low
- dp_o  out  1  decimal point, active-low
- an_o  out  DIGITS  anodes, active-low

Behaviour:
- Reset is asynchronous on presetn_i low. Reset values:
  - Outputs: an_o all 1, seg_o 7'h7F, dp_o 1, prdata_o 0, pslverr_o 0.
  - Registers: DATA=0, CTRL=0x0000_0001, DIV=DEFAULT_DIV, BRIGHT=16.
  - Counters: digit index, slot counter and PWM counter all 0.
- Register map (word-aligned):
  - 0x00 DATA RW: nibble i = hex value of digit i. Bits at and above 4*DIGITS are not stored and read 0.
  - 0x04 CTRL RW: [0] EN; [15:8] DP mask; [23:16] BLANK mask. Mask bits at and above DIGITS read 0. Other bits read 0.
  - 0x08 DIV RW: [DIV_W-1:0]. A written value of 0 is stored as 1.
  - 0x0C BRIGHT RW: [4:0], saturates at 16 on write.
  - 0x10 STATUS RO: [2:0] current digit index; [8] EN.
- APB handshake:
  - pready_o is combinationally 1 whenever psel_i is high, so every transfer completes with zero wait states.
  - Writes commit on the rising edge where psel_i, penable_i and pwrite_i are all 1.
  - pstrb_i is honoured per byte; bytes with strobe 0 are unchanged.
  - prdata_o is driven only in the access phase of a read (psel_i & penable_i & ~pwrite_i); otherwise it is 0.
- pslverr_o is asserted only in the access phase, and only when the address is misaligned (paddr_i[1:0]≠0), outside 0x00..0x10, or when writing STATUS.
  - An erroring write changes no register.
  - An erroring read returns 0.
- Scan engine:
  - When EN=1, the slot counter increments every clock.
  - When slot counter ≥ DIV: slot counter→0 and index→index+1, wrapping DIGITS-1→0. The ≥ comparison means lowering DIV mid-slot never stalls the scan.
- PWM:
  - A free-running 4-bit PWM counter increments every clock while EN=1.
  - Digit enabled ⇔ EN & ~BLANK[index] & (pwm < BRIGHT). BRIGHT=16 means always on; BRIGHT=0 means always off.
- Outputs are registered, with one clock latency from the index/PWM state:
  - an_o[index]=0 when the digit is enabled; every other anode is 1.
  - seg_o = inverted hex-to-7-segment decode of DATA nibble[index], or 7'h7F when the digit is disabled.
  - dp_o = ~(DP[index] & enabled).
- EN write 1→0: on the next clock all anodes go to 1, seg_o goes to 7'h7F, and index, slot and PWM counters go to 0. EN 0→1 restarts the scan at digit 0.
- Write to DATA/CTRL/BRIGHT mid-slot: the new value is visible on the outputs 1 clock after the commit edge. No tearing of the current index.
- Reset asserted mid-transfer: the transfer is aborted and all registers take their reset values immediately.

Test Plan:
- Reset, then read each register -> DATA=0, CTRL=0x1, DIV=49999, BRIGHT=16, STATUS=0x100. Check an_o=8'hFF during reset and seg_o=7'h7F.
- DIV=3, DATA=0x76543210, BRIGHT=16:
  - Each anode is low for 4 clocks in order 0..7, then wraps to 0.
  - Digit 0 shows seg_o=~7'h3F; digit 1 shows seg_o=~7'h06.
- Write DATA=0xFFFFFFFF with pstrb=4'b0010 over 0 -> reads back 0x0000FF00. Writing CTRL BLANK=0x04 -> an_o[2] never low and scan timing unchanged.
- BRIGHT=4, DIV=31 -> within each slot the active anode is low exactly 4 of every 16 clocks. BRIGHT=0 -> an_o stays 8'hFF.
- Error cases:
  - Read 0x14 -> pslverr=1, prdata=0.
  - Write 0x02 -> pslverr=1, no register change.
  - Write STATUS -> pslverr=1.
  - Valid accesses -> pslverr=0, pready=1 in the access phase.
- EN=0 mid-scan at index 5 -> next clock an_o=8'hFF and STATUS=0. Re-enable -> digit 0 lights first. Writing DIV=0 -> reads 1 and slot length is 2 clocks.
